priority_event_tracker: RTL and testbench

Downstream consumer of the 3-input priority detector's one-hot code {outZ,outY,outX}.
- Debounces the code: it must be stable for STABLE_CYCLES consecutive samples before it is accepted.
- Issues exactly one event per accepted code over a valid/ready handshake, then requires the code to return to 000 before re-arming.
- Flags illegal multi-hot codes and, optionally, keeps per-class occurrence counters.

---
 rtl/priority_event_tracker.sv | 155 +++++++++++++++
 tb/tb_priority_event_tracker.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/priority_event_tracker.sv
// rtl/priority_event_tracker.sv - debounced one-hot priority code to single-event tracker
//
// Optional feature macro: PRIO_EVT_COUNT_EN (per-class saturating counters).
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   code_in    one-hot priority code {z,y,x}; 000 = no request
//   evt_ready  downstream accepts the pending event
//   clr        synchronous clear of counters and err_multi
//   evt_valid  event pending
//   evt_code   accepted one-hot code, stable while evt_valid=1
//   evt_idx    encoded class: 0=X, 1=Y, 2=Z
//   busy       high whenever the FSM is not in IDLE
//   err_multi  sticky multi-hot sample flag
//   cnt_x/y/z  accepted-event counters (tied to 0 without PRIO_EVT_COUNT_EN)
module priority_event_tracker #(
    parameter int STABLE_CYCLES = 3,
    parameter int CNT_W         = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       code_in,
    input  logic             evt_ready,
    input  logic             clr,
    output logic             evt_valid,
    output logic [2:0]       evt_code,
    output logic [1:0]       evt_idx,
    output logic             busy,
    output logic             err_multi,
    output logic [CNT_W-1:0] cnt_x,
    output logic [CNT_W-1:0] cnt_y,
    output logic [CNT_W-1:0] cnt_z
);

    typedef enum logic [1:0] {IDLE, SETTLE, EMIT, REARM} state_t;

    localparam logic [7:0] STABLE_LAST = 8'(STABLE_CYCLES);
    localparam bit         ONE_SHOT    = (STABLE_CYCLES == 1);

    state_t     state;
    logic [2:0] cand;
    logic [7:0] stab_cnt;

    logic       multi;
    logic [2:0] sample;
    logic       fire;

    function automatic logic [1:0] encode(input logic [2:0] c);
        logic [1:0] r;
        r = 2'd0;
        if (c[1]) r = 2'd1;
        if (c[2]) r = 2'd2;
        return r;
    endfunction

    // Any two bits set is illegal; such a sample behaves like "no request".
    assign multi  = (code_in[0] & code_in[1]) | (code_in[0] & code_in[2]) | (code_in[1] & code_in[2]);
    assign sample = multi ? 3'b000 : code_in;

    // fire marks the edge on which the FSM enters EMIT; counters key off it.
    always_comb begin
        fire = 1'b0;
        if (state == IDLE && sample != 3'b000 && ONE_SHOT)
            fire = 1'b1;
        else if (state == SETTLE && sample != 3'b000 && sample == cand &&
                 (stab_cnt + 8'd1) == STABLE_LAST)
            fire = 1'b1;
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cand      <= 3'b000;
            stab_cnt  <= 8'd0;
            evt_valid <= 1'b0;
            evt_code  <= 3'b000;
            evt_idx   <= 2'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (sample != 3'b000) begin
                        cand     <= sample;
                        stab_cnt <= 8'd1;
                        if (fire) begin
                            state     <= EMIT;
                            evt_valid <= 1'b1;
                            evt_code  <= sample;
                            evt_idx   <= encode(sample);
                        end else begin
                            state <= SETTLE;
                        end
                    end
                end
                SETTLE: begin
                    if (sample == 3'b000) begin
                        state <= IDLE;
                    end else if (sample != cand) begin
                        cand     <= sample;
                        stab_cnt <= 8'd1;
                    end else if (fire) begin
                        state     <= EMIT;
                        evt_valid <= 1'b1;
                        evt_code  <= cand;
                        evt_idx   <= encode(cand);
                    end else begin
                        stab_cnt <= stab_cnt + 8'd1;
                    end
                end
                EMIT: begin
                    // code_in is ignored here; evt_code keeps its value after the handshake.
                    if (evt_ready) begin
                        evt_valid <= 1'b0;
                        state     <= REARM;
                    end
                end
                REARM: begin
                    if (sample == 3'b000) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Set beats clear when both land on the same edge.
    always_ff @(posedge clk) begin
        if (rst)        err_multi <= 1'b0;
        else if (multi) err_multi <= 1'b1;
        else if (clr)   err_multi <= 1'b0;
    end

`ifdef PRIO_EVT_COUNT_EN
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // Clear beats a coincident increment.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt_x <= '0;
            cnt_y <= '0;
            cnt_z <= '0;
        end else if (fire) begin
            if (sample[0] && cnt_x != CNT_MAX) cnt_x <= cnt_x + 1'b1;
            if (sample[1] && cnt_y != CNT_MAX) cnt_y <= cnt_y + 1'b1;
            if (sample[2] && cnt_z != CNT_MAX) cnt_z <= cnt_z + 1'b1;
        end
    end
`else
    assign cnt_x = '0;
    assign cnt_y = '0;
    assign cnt_z = '0;
`endif

endmodule

// File: tb/tb_priority_event_tracker.sv
// tb/tb_priority_event_tracker.sv - bench for priority_event_tracker
module tb_priority_event_tracker;

`ifdef PRIO_EVT_COUNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] code_in = 3'b000;
    logic       evt_ready = 1'b0;
    logic       clr = 1'b0;

    // Instance a: default parameters. Instance b: STABLE_CYCLES=1, CNT_W=2.
    logic       a_valid, a_busy, a_err;
    logic [2:0] a_code;
    logic [1:0] a_idx;
    logic [7:0] a_cx, a_cy, a_cz;
    logic       b_valid, b_busy, b_err;
    logic [2:0] b_code;
    logic [1:0] b_idx;
    logic [1:0] b_cx, b_cy, b_cz;

    priority_event_tracker dut_a (
        .clk(clk), .rst(rst), .code_in(code_in), .evt_ready(evt_ready), .clr(clr),
        .evt_valid(a_valid), .evt_code(a_code), .evt_idx(a_idx), .busy(a_busy),
        .err_multi(a_err), .cnt_x(a_cx), .cnt_y(a_cy), .cnt_z(a_cz)
    );

    priority_event_tracker #(.STABLE_CYCLES(1), .CNT_W(2)) dut_b (
        .clk(clk), .rst(rst), .code_in(code_in), .evt_ready(evt_ready), .clr(clr),
        .evt_valid(b_valid), .evt_code(b_code), .evt_idx(b_idx), .busy(b_busy),
        .err_multi(b_err), .cnt_x(b_cx), .cnt_y(b_cy), .cnt_z(b_cz)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Reference model: run length of identical legal samples, an armed flag
    // (cleared after each accepted event until the code returns to idle) and
    // a pending flag for the outstanding event.
    int n_req[2]   = '{3, 1};
    int cmax[2]    = '{255, 3};
    int m_armed[2], m_pending[2], m_run[2], m_last[2];
    int m_code[2], m_idx[2], m_err[2];
    int m_cnt[2][3];

    function automatic int cls(input int c);
        return (c == 1) ? 0 : (c == 2) ? 1 : 2;
    endfunction

    task automatic model_edge(input int k);
        int s;
        bit mh;
        mh = ($countones(code_in) > 1);
        s  = mh ? 0 : int'(code_in);
        if (rst) begin
            m_armed[k] = 1; m_pending[k] = 0; m_run[k] = 0; m_last[k] = 0;
            m_code[k] = 0; m_idx[k] = 0; m_err[k] = 0;
            for (int j = 0; j < 3; j++) m_cnt[k][j] = 0;
            return;
        end
        if (mh) m_err[k] = 1;
        else if (clr) m_err[k] = 0;
        if (m_pending[k] != 0) begin
            if (evt_ready) begin
                m_pending[k] = 0;
                m_armed[k] = 0;
            end
        end else if (m_armed[k] == 0) begin
            if (s == 0) begin
                m_armed[k] = 1;
                m_run[k] = 0;
            end
        end else begin
            if (s == 0) m_run[k] = 0;
            else if (s == m_last[k]) m_run[k] = m_run[k] + 1;
            else m_run[k] = 1;
            m_last[k] = s;
            if (s != 0 && m_run[k] == n_req[k]) begin
                m_pending[k] = 1;
                m_code[k] = s;
                m_idx[k] = cls(s);
                if (!clr && m_cnt[k][cls(s)] < cmax[k]) m_cnt[k][cls(s)]++;
            end
        end
        if (clr) for (int j = 0; j < 3; j++) m_cnt[k][j] = 0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int ec(input int k, input int j);
        return CNT_EN ? m_cnt[k][j] : 0;
    endfunction

    task automatic compare_all();
        chk("a_valid", 32'(a_valid), 32'(m_pending[0]));
        chk("a_code",  32'(a_code),  32'(m_code[0]));
        chk("a_idx",   32'(a_idx),   32'(m_idx[0]));
        chk("a_busy",  32'(a_busy),  32'(m_pending[0] != 0 || m_armed[0] == 0 || m_run[0] > 0));
        chk("a_err",   32'(a_err),   32'(m_err[0]));
        chk("a_cnt_x", 32'(a_cx),    32'(ec(0, 0)));
        chk("a_cnt_y", 32'(a_cy),    32'(ec(0, 1)));
        chk("a_cnt_z", 32'(a_cz),    32'(ec(0, 2)));
        chk("b_valid", 32'(b_valid), 32'(m_pending[1]));
        chk("b_code",  32'(b_code),  32'(m_code[1]));
        chk("b_idx",   32'(b_idx),   32'(m_idx[1]));
        chk("b_busy",  32'(b_busy),  32'(m_pending[1] != 0 || m_armed[1] == 0 || m_run[1] > 0));
        chk("b_err",   32'(b_err),   32'(m_err[1]));
        chk("b_cnt_x", 32'(b_cx),    32'(ec(1, 0)));
        chk("b_cnt_y", 32'(b_cy),    32'(ec(1, 1)));
        chk("b_cnt_z", 32'(b_cz),    32'(ec(1, 2)));
    endtask

    task automatic step(input logic [2:0] c, input logic r, input logic cl, input logic rs);
        code_in = c; evt_ready = r; clr = cl; rst = rs;
        @(posedge clk);
        model_edge(0);
        model_edge(1);
        #1;
        compare_all();
        @(negedge clk);
    endtask

    initial begin
        @(negedge clk);
        step(3'b000, 1'b0, 1'b0, 1'b1);
        step(3'b000, 1'b0, 1'b0, 1'b1);
        chk("rst_valid", 32'(a_valid), 32'd0);
        chk("rst_busy",  32'(a_busy),  32'd0);

        // 010 held with ready high: one-cycle event after edge 3, none until 000.
        step(3'b010, 1'b1, 1'b0, 1'b0);
        step(3'b010, 1'b1, 1'b0, 1'b0);
        chk("tp1_not_yet", 32'(a_valid), 32'd0);
        step(3'b010, 1'b1, 1'b0, 1'b0);
        chk("tp1_valid", 32'(a_valid), 32'd1);
        chk("tp1_code",  32'(a_code),  32'd2);
        chk("tp1_idx",   32'(a_idx),   32'd1);
        chk("tp1_cnt_y", 32'(a_cy),    CNT_EN ? 32'd1 : 32'd0);
        step(3'b010, 1'b1, 1'b0, 1'b0);
        chk("tp1_drop",  32'(a_valid), 32'd0);
        repeat (4) step(3'b010, 1'b1, 1'b0, 1'b0);
        step(3'b000, 1'b1, 1'b0, 1'b0);
        step(3'b000, 1'b1, 1'b0, 1'b0);

        // 001,001,100,100,100 -> single Z event.
        step(3'b001, 1'b0, 1'b0, 1'b0);
        step(3'b001, 1'b0, 1'b0, 1'b0);
        step(3'b100, 1'b0, 1'b0, 1'b0);
        step(3'b100, 1'b0, 1'b0, 1'b0);
        step(3'b100, 1'b0, 1'b0, 1'b0);
        chk("tp2_code", 32'(a_code), 32'd4);
        chk("tp2_cnt_x", 32'(a_cx), 32'd0);
        step(3'b100, 1'b1, 1'b0, 1'b0);
        step(3'b000, 1'b0, 1'b0, 1'b0);

        // X event stalled with ready low while code_in toggles.
        repeat (3) step(3'b001, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) step((i % 2) ? 3'b100 : 3'b010, 1'b0, 1'b0, 1'b0);
        chk("tp3_hold_valid", 32'(a_valid), 32'd1);
        chk("tp3_hold_code",  32'(a_code),  32'd1);
        step(3'b010, 1'b1, 1'b0, 1'b0);
        chk("tp3_rearm_busy", 32'(a_busy), 32'd1);
        step(3'b000, 1'b0, 1'b0, 1'b0);

        // Multi-hot flag, clear, and set-beats-clear.
        step(3'b110, 1'b1, 1'b0, 1'b0);
        chk("tp4_err", 32'(a_err), 32'd1);
        step(3'b000, 1'b1, 1'b1, 1'b0);
        chk("tp4_clr", 32'(a_err), 32'd0);
        step(3'b011, 1'b1, 1'b1, 1'b0);
        chk("tp4_set_wins", 32'(a_err), 32'd1);
        step(3'b000, 1'b1, 1'b1, 1'b0);

        // Saturation on the 2-bit instance, then clr beating an increment.
        for (int i = 0; i < 5; i++) begin
            step(3'b001, 1'b1, 1'b0, 1'b0);
            step(3'b000, 1'b1, 1'b0, 1'b0);
            step(3'b000, 1'b1, 1'b0, 1'b0);
        end
        chk("tp5_sat", 32'(b_cx), CNT_EN ? 32'd3 : 32'd0);
        step(3'b001, 1'b1, 1'b1, 1'b0);
        chk("tp5_clr_wins", 32'(b_cx), 32'd0);
        step(3'b000, 1'b1, 1'b0, 1'b0);
        step(3'b000, 1'b1, 1'b0, 1'b0);

        // Reset while an event is pending, then a fresh Z event.
        repeat (3) step(3'b010, 1'b0, 1'b0, 1'b0);
        chk("tp6_pending", 32'(a_valid), 32'd1);
        step(3'b010, 1'b0, 1'b0, 1'b1);
        chk("tp6_valid", 32'(a_valid), 32'd0);
        chk("tp6_busy",  32'(a_busy),  32'd0);
        chk("tp6_cnt_y", 32'(a_cy),    32'd0);
        repeat (3) step(3'b100, 1'b1, 1'b0, 1'b0);
        chk("tp6_fresh", 32'(a_valid), 32'd1);

        // Randomized phase: held codes of random length, random ready/clr/rst.
        for (int i = 0; i < 300; i++) begin
            logic [2:0] c;
            int len, pick;
            pick = int'($urandom_range(0, 9));
            case (pick)
                0, 1, 2: c = 3'b000;
                3, 4:    c = 3'b001;
                5, 6:    c = 3'b010;
                7, 8:    c = 3'b100;
                default: c = 3'(($urandom_range(0, 3) == 0) ? 7 : 3 + 2 * $urandom_range(0, 1));
            endcase
            len = int'($urandom_range(1, 5));
            for (int j = 0; j < len; j++)
                step(c, $urandom_range(0, 2) != 0, $urandom_range(0, 15) == 0,
                     $urandom_range(0, 60) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
